kbd_cmd_queue: RTL and testbench

Downstream consumer of the PS/2 receiver (`kbd_protocol`). It detects each new key-release event flagged on `check` and translates the accompanying `scancode` into a 2-bit game command. Commands are buffered in a small show-ahead FIFO with a valid/ready pop handshake. This lets the game FSM consume keystrokes at its own pace without losing events that arrive during long operations.

---
 rtl/kbd_pkg.sv | 35 +++
 rtl/sync_fifo.sv | 54 +++++
 rtl/kbd_cmd_queue.sv | 63 ++++++
 tb/tb_kbd_cmd_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared keyboard definitions: PS/2 release scancodes and the 2-bit game commands
// they map to. The game FSM imports the same constants.
package kbd_pkg;

  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_Q = 8'h15;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_X = 8'h22;

  localparam logic [1:0] CMD_F = 2'd0;
  localparam logic [1:0] CMD_Q = 2'd1;
  localparam logic [1:0] CMD_H = 2'd2;
  localparam logic [1:0] CMD_X = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] cmd;
  } decode_t;

  // Unmapped scancodes come back with valid=0 and a harmless cmd of 0.
  function automatic decode_t decode_scancode(input logic [7:0] sc);
    decode_t d;
    d.valid = 1'b1;
    d.cmd   = CMD_F;
    case (sc)
      SC_F:    d.cmd = CMD_F;
      SC_Q:    d.cmd = CMD_Q;
      SC_H:    d.cmd = CMD_H;
      SC_X:    d.cmd = CMD_X;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a separately tracked occupancy count.
// A push while full is only accepted when a pop frees a slot in the same cycle.
module sync_fifo
  import kbd_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is forced to zero when empty so the output never carries stale data.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/kbd_cmd_queue.sv
// Turns key-release events from the PS/2 receiver into queued game commands,
// flagging dropped events (queue full) and unmapped scancodes as sticky errors.
module kbd_cmd_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    scancode,
  input  logic          check,
  input  logic          cmd_ready,
  output logic          cmd_valid,
  output logic [1:0]    cmd,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          bad_code
);

  logic    check_q;
  logic    key_event;
  decode_t decoded;
  logic    fifo_full;
  logic    fifo_empty;
  logic    pop;
  logic    push;

  // check stays high until the next packet, so only its rising edge is an event.
  assign key_event = check & ~check_q;
  assign decoded   = decode_scancode(scancode);
  assign cmd_valid = ~fifo_empty;
  assign pop       = cmd_valid & cmd_ready;
  assign push      = key_event & decoded.valid & (~fifo_full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      check_q  <= 1'b0;
      overflow <= 1'b0;
      bad_code <= 1'b0;
    end else begin
      check_q <= check;
      if (key_event && decoded.valid && fifo_full && !pop) overflow <= 1'b1;
      if (key_event && !decoded.valid)                     bad_code <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH(2),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (decoded.cmd),
    .pop   (pop),
    .rdata (cmd),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_kbd_cmd_queue.sv
// Bench for kbd_cmd_queue: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based model.
module tb_kbd_cmd_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    scancode = 8'h00;
  logic          check = 1'b0;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic [1:0]    cmd;
  logic [CW-1:0] count;
  logic          overflow;
  logic          bad_code;

  int total = 0;
  int bad = 0;

  kbd_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .scancode  (scancode),
    .check     (check),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .count     (count),
    .overflow  (overflow),
    .bad_code  (bad_code)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of commands plus the previous check level and flags.
  logic [1:0] m_q[$];
  bit         m_check_prev = 0;
  bit         m_overflow = 0;
  bit         m_bad = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_check_prev = 0;
      m_overflow   = 0;
      m_bad        = 0;
    end else begin
      bit       ev;
      bit       popping;
      bit       mapped;
      bit [1:0] c;
      ev           = check && !m_check_prev;
      m_check_prev = check;
      popping      = (m_q.size() > 0) && cmd_ready;
      mapped       = 1;
      c            = 0;
      case (scancode)
        8'h2B:   c = 0;
        8'h15:   c = 1;
        8'h33:   c = 2;
        8'h22:   c = 3;
        default: mapped = 0;
      endcase
      if (popping) void'(m_q.pop_front());
      if (ev) begin
        if (!mapped)                   m_bad = 1;
        else if (m_q.size() < DEPTH)   m_q.push_back(c);
        else                           m_overflow = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, required, $time);
    end
  endtask

  // Every negedge: DUT outputs against the model.
  always @(negedge clk) begin
    int exp_cmd;
    exp_cmd = (m_q.size() > 0) ? int'(m_q[0]) : 0;
    checkOutput("model_cmd_valid", int'(cmd_valid), int'(m_q.size() > 0));
    checkOutput("model_cmd",       int'(cmd),       exp_cmd);
    checkOutput("model_count",     int'(count),     m_q.size());
    checkOutput("model_overflow",  int'(overflow),  int'(m_overflow));
    checkOutput("model_bad_code",  int'(bad_code),  int'(m_bad));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] sc, input logic chk, input logic rdy);
    scancode  = sc;
    check     = chk;
    cmd_ready = rdy;
    tick();
  endtask

  task automatic keyEvent(input logic [7:0] sc, input logic rdy);
    applyStimulus(sc, 1'b1, rdy);
    applyStimulus(sc, 1'b0, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) tick();
    reset = 0;
    tick();
    checkOutput("reset_cmd_valid", int'(cmd_valid), 0);
    checkOutput("reset_count",     int'(count),     0);

    // Long check pulse yields one entry.
    applyStimulus(8'h33, 1'b1, 1'b0);
    checkOutput("pulse_count_first", int'(count), 1);
    checkOutput("pulse_cmd_first",   int'(cmd),   2);
    for (int i = 0; i < 199; i++) applyStimulus(8'h33, 1'b1, 1'b0);
    checkOutput("pulse_count_held", int'(count), 1);
    applyStimulus(8'h33, 1'b0, 1'b1);
    checkOutput("pulse_drained", int'(count), 0);

    // F, Q, H, X then drain in order.
    keyEvent(8'h2B, 0); keyEvent(8'h15, 0); keyEvent(8'h33, 0); keyEvent(8'h22, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_cmd",   int'(cmd),   i);
      checkOutput("drain_count", int'(count), 4 - i);
      applyStimulus(8'h00, 1'b0, 1'b1);
    end
    checkOutput("drain_valid_low", int'(cmd_valid), 0);

    // Overflow while full, then a push that coincides with a pop.
    keyEvent(8'h2B, 0); keyEvent(8'h15, 0); keyEvent(8'h33, 0); keyEvent(8'h22, 0);
    keyEvent(8'h22, 0);
    checkOutput("ovf_flag",  int'(overflow), 1);
    checkOutput("ovf_count", int'(count),    4);
    checkOutput("ovf_head",  int'(cmd),      0);
    keyEvent(8'h22, 1);
    checkOutput("ovf_pop_count", int'(count),    4);
    checkOutput("ovf_pop_head",  int'(cmd),      1);
    checkOutput("ovf_sticky",    int'(overflow), 1);

    // Unmapped scancode.
    keyEvent(8'h1C, 0);
    checkOutput("bad_flag",  int'(bad_code), 1);
    checkOutput("bad_count", int'(count),    4);
    for (int i = 0; i < 5; i++) applyStimulus(8'h00, 1'b0, 1'b1);

    // Same key twice with a one-cycle gap.
    applyStimulus(8'h2B, 1'b1, 1'b0);
    applyStimulus(8'h2B, 1'b0, 1'b0);
    applyStimulus(8'h2B, 1'b1, 1'b0);
    applyStimulus(8'h2B, 1'b0, 1'b0);
    checkOutput("repeat_count", int'(count), 2);
    checkOutput("repeat_cmd",   int'(cmd),   0);

    // Asynchronous reset mid-clock with three entries queued.
    keyEvent(8'h15, 0);
    checkOutput("prereset_count", int'(count), 3);
    #2 reset = 1;
    #1;
    checkOutput("async_valid",    int'(cmd_valid), 0);
    checkOutput("async_count",    int'(count),     0);
    checkOutput("async_cmd",      int'(cmd),       0);
    checkOutput("async_overflow", int'(overflow),  0);
    checkOutput("async_bad",      int'(bad_code),  0);
    #1 reset = 0;
    tick();
    keyEvent(8'h33, 0);
    checkOutput("post_reset_count", int'(count), 1);
    checkOutput("post_reset_cmd",   int'(cmd),   2);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] sc;
      case ($urandom_range(0, 9))
        0, 1:    sc = 8'h2B;
        2, 3:    sc = 8'h15;
        4, 5:    sc = 8'h33;
        6, 7:    sc = 8'h22;
        default: sc = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 999) == 0) begin
        reset = 1;
        tick();
        reset = 0;
      end
      applyStimulus(check ? scancode : sc,
                    ($urandom_range(0, 3) == 0) ? ~check : check,
                    1'($urandom_range(0, 2) == 0));
    end

    check = 0;
    cmd_ready = 1;
    repeat (8) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
